// File: rtl/gray_counter_core_pkg.sv
// Shared definitions for the Gray-code step counter: FSM encoding and default width.
package gray_counter_core_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

endpackage

// File: rtl/gray_counter_core_if.sv
// Control and count bus of the Gray-code step counter, with the FSM state exposed for checkers.
interface gray_counter_core_if
  import gray_counter_core_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  // pulse is a one-cycle strobe with no back-pressure: it is consumed on the edge
  // where it is high (if the counter is running) and never held or retried.
  logic         pulse;
  logic         start;
  logic         dir;
  logic         clr;
  logic [N-1:0] gray;
  logic [N-1:0] bin;
  logic         wrap;
  logic         running;
  state_t       state;

  modport master (
    output pulse, start, dir, clr,
    input  gray, bin, wrap, running, state
  );

  modport slave (
    input  pulse, start, dir, clr,
    output gray, bin, wrap, running, state
  );

endinterface

// File: rtl/gray_counter_edge.sv
// Rising-edge detector for the start request; history resets high so a level held through reset is not an edge.
module gray_counter_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev <= 1'b1;
    end else begin
      prev <= d;
    end
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/gray_counter_core.sv
// Run/pause controlled up/down counter stepped by an external strobe, with registered binary and Gray outputs.
module gray_counter_core
  import gray_counter_core_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  gray_counter_core_if.slave bus
);

  localparam logic [N-1:0] MAX  = {N{1'b1}};
  localparam logic [N-1:0] ZERO = {N{1'b0}};
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t       state;
  state_t       next_state;
  logic [N-1:0] b;
  logic [N-1:0] next_b;
  logic [N-1:0] gray_q;
  logic         wrap_q;
  logic         running_q;
  logic         wrap_nxt;
  logic         start_rise;
  logic         step;

  gray_counter_edge u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.start),
    .rise (start_rise)
  );

  // A step uses the state before this edge, so a start edge in RUN still steps once.
  assign step = bus.pulse && (state == RUN);

  always_comb begin
    next_b   = b;
    wrap_nxt = 1'b0;
    if (step) begin
      if (bus.dir) begin
        if (b == MAX) begin
          if (WRAP_EN) begin
            next_b   = ZERO;
            wrap_nxt = 1'b1;
          end
        end else begin
          next_b = b + ONE;
        end
      end else begin
        if (b == ZERO) begin
          if (WRAP_EN) begin
            next_b   = MAX;
            wrap_nxt = 1'b1;
          end
        end else begin
          next_b = b - ONE;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_rise) next_state = RUN;
      RUN:     if (start_rise) next_state = PAUSE;
      PAUSE:   if (start_rise) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      b         <= ZERO;
      gray_q    <= ZERO;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else if (bus.clr) begin
      state     <= IDLE;
      b         <= ZERO;
      gray_q    <= ZERO;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= next_state;
      b         <= next_b;
      gray_q    <= next_b ^ (next_b >> 1);
      wrap_q    <= wrap_nxt;
      running_q <= (next_state == RUN);
    end
  end

  assign bus.bin     = b;
  assign bus.gray    = gray_q;
  assign bus.wrap    = wrap_q;
  assign bus.running = running_q;
  assign bus.state   = state;

endmodule

// File: tb/tb_gray_counter_core.sv
// Directed bench for gray_counter_core: a wrapping and a saturating instance driven by the same vectors.
module tb_gray_counter_core;
  import gray_counter_core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  gray_counter_core_if #(.N(4)) bus_a ();
  gray_counter_core_if #(.N(4)) bus_b ();

  gray_counter_core #(.N(4), .WRAP_EN(1'b1)) u_wrap (.clk(clk), .rst(rst), .bus(bus_a));
  gray_counter_core #(.N(4), .WRAP_EN(1'b0)) u_sat  (.clk(clk), .rst(rst), .bus(bus_b));

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic p, input logic s, input logic d, input logic c);
    bus_a.pulse = p; bus_a.start = s; bus_a.dir = d; bus_a.clr = c;
    bus_b.pulse = p; bus_b.start = s; bus_b.dir = d; bus_b.clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [3:0] gray_tab [16];
  logic [3:0] prev_gray;

  initial begin
    gray_tab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    // reset with start held high
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check("rst_gray", bus_a.gray, 4'h0);
    check("rst_bin", bus_a.bin, 4'h0);
    check("rst_wrap", bus_a.wrap, 1'b0);
    check("rst_running", bus_a.running, 1'b0);
    check("rst_state", bus_a.state, IDLE);
    #4 rst = 1'b1;

    // start held through release is not an edge; pulses ignored
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      check("hold_running", bus_a.running, 1'b0);
      check("hold_gray", bus_a.gray, 4'h0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("start_running", bus_a.running, 1'b1);
    check("start_state", bus_a.state, RUN);

    // full up cycle
    prev_gray = 4'h0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("up_gray", bus_a.gray, gray_tab[i]);
      check("up_wrap", bus_a.wrap, (i == 15) ? 1'b1 : 1'b0);
      check("up_onebit", $countones(prev_gray ^ bus_a.gray), 1);
      prev_gray = bus_a.gray;
    end
    check("sat_up_bin", bus_b.bin, 4'hF);
    check("sat_up_wrap", bus_b.wrap, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("up_wrap_drop", bus_a.wrap, 1'b0);

    // clr then down-wrap from zero
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("clr_bin", bus_a.bin, 4'h0);
    check("clr_running", bus_a.running, 1'b0);
    check("clr_state", bus_a.state, IDLE);
    check("clr_sat_bin", bus_b.bin, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("restart_running", bus_a.running, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("down_bin", bus_a.bin, 4'hF);
    check("down_gray", bus_a.gray, 4'b1000);
    check("down_wrap", bus_a.wrap, 1'b1);
    check("sat_down_bin", bus_b.bin, 4'h0);
    check("sat_down_gray", bus_b.gray, 4'h0);
    check("sat_down_wrap", bus_b.wrap, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("down_wrap_drop", bus_a.wrap, 1'b0);
    check("down_bin_hold", bus_a.bin, 4'hF);

    // pause with step in the same cycle
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    check("five_bin", bus_a.bin, 4'h5);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("pause_bin", bus_a.bin, 4'h6);
    check("pause_gray", bus_a.gray, 4'b0101);
    check("pause_running", bus_a.running, 1'b0);
    check("pause_state", bus_a.state, PAUSE);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("paused_bin", bus_a.bin, 4'h6);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("resume_running", bus_a.running, 1'b1);
    check("resume_nostep", bus_a.bin, 4'h6);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("dir_only_bin", bus_a.bin, 4'h6);
    check("dir_only_state", bus_a.state, RUN);

    // clr beats start edge and pulse
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    check("nine_bin", bus_a.bin, 4'h9);
    check("nine_gray", bus_a.gray, 4'b1101);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("clr_win_bin", bus_a.bin, 4'h0);
    check("clr_win_gray", bus_a.gray, 4'h0);
    check("clr_win_running", bus_a.running, 1'b0);
    check("clr_win_state", bus_a.state, IDLE);

    // asynchronous reset mid-count
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    check("seven_bin", bus_a.bin, 4'h7);
    check("seven_gray", bus_a.gray, 4'b0100);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("arst_gray", bus_a.gray, 4'h0);
    check("arst_bin", bus_a.bin, 4'h0);
    check("arst_wrap", bus_a.wrap, 1'b0);
    check("arst_running", bus_a.running, 1'b0);
    tick();
    #4 rst = 1'b1;
    tick();
    check("post_rst_state", bus_a.state, IDLE);
    check("post_rst_running", bus_a.running, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("post_rst_nostep", bus_a.bin, 4'h0);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gray_counter_core.md
GRAY_COUNTER_CORE -- requirements
Module: gray_counter_core

Interface
REQ-001 Parameter N, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter WRAP_EN, default 1: 1 = modulo-2^N wrap; 0 = saturate at 0 and 2^N-1.
REQ-003 Port clk  input  1  system clock, rising-edge active.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port pulse  input  1  one-cycle step strobe from the 1 Hz pulse generator; synchronous to clk.
REQ-006 Port start  input  1  synchronous run/pause request; level input, a rising edge acts as a toggle.
REQ-007 Port dir  input  1  count direction: 1 = up, 0 = down; sampled only on a step cycle.
REQ-008 Port clr  input  1  synchronous clear, active-high.
REQ-009 Port gray  output  N  registered Gray-coded count.
REQ-010 Port bin  output  N  registered binary count, same cycle as gray.
REQ-011 Port wrap  output  1  registered one-cycle flag, high on wrap-around.
REQ-012 Port running  output  1  high when the FSM is in RUN.

Function
REQ-013 Internal binary count b (N bits); gray SHALL equal b ^ (b >> 1), registered together with b.
REQ-014 FSM states: IDLE, RUN, PAUSE.
REQ-015 Start edge (start high now, previous sample low) transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-016 clr SHALL force IDLE and b = 0 from any state on the next edge, overriding the start edge and pulse in the same cycle.
REQ-017 Step: pulse high while state == RUN. Up adds 1 to b, down subtracts 1, both on the same clock edge; latency is 1 cycle from pulse to updated gray/bin.
REQ-018 In IDLE and PAUSE, pulse SHALL be ignored and b held.
REQ-019 Start edge and pulse in the same cycle while in RUN: the step SHALL be applied and the state SHALL go to PAUSE.
REQ-020 Start edge and pulse in the same cycle while in IDLE or PAUSE: go to RUN with no step.
REQ-021 WRAP_EN=1: up from 2^N-1 gives 0, down from 0 gives 2^N-1. wrap SHALL be high for exactly the one cycle in which the wrapped value first appears on gray/bin.
REQ-022 WRAP_EN=0: up at 2^N-1 and down at 0 hold b, and wrap SHALL stay 0.
REQ-023 Consecutive gray values produced by steps SHALL differ in exactly one bit.
REQ-024 A dir change takes effect on the next step only and has no effect on state.
REQ-025 running SHALL be registered and equal (state == RUN).

Reset
REQ-026 While rst is low: state = IDLE, b = 0, gray = 0, bin = 0, wrap = 0, running = 0.
REQ-027 The start-edge history register SHALL reset to 1, so a start held high through reset release does not trigger RUN.
REQ-028 Reset asserted mid-count SHALL clear everything immediately, without waiting for clk.
REQ-029 Reset release SHALL be synchronous to clk; the first step is possible only after a start edge.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding (IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10) and the default N.
REQ-031 One sub-module, gray_counter_edge, SHALL provide rising-edge detection on start, with its own reset-to-1 history flop.
REQ-032 The binary-to-Gray conversion SHALL be inline combinational logic feeding the output register, not a separate module.
REQ-033 No clock gating; all flops SHALL be on clk with asynchronous rst.

Verification (N=4)
REQ-034 Release rst with start held high, then 5 pulses: running=0, gray=0000 throughout.
REQ-035 Start edge, dir=1, 16 pulses: gray follows 0001,0011,0010,...,1000,0000. wrap is high exactly once, on the cycle gray returns to 0000, and each step changes exactly 1 bit.
REQ-036 Running at b=0, dir=0, one pulse: bin=1111, gray=1000, wrap=1 for one cycle. Repeat with WRAP_EN=0: bin stays 0000, wrap=0.
REQ-037 Running at b=5, start edge and pulse in the same cycle: bin=6, running=0. Then 3 pulses: bin stays 6. Then a start edge: running=1.
REQ-038 clr, start edge and pulse in the same cycle at b=9: next cycle bin=0, running=0, state IDLE.
REQ-039 rst driven low between clock edges at b=7: gray/bin=0 and wrap=0 with no clock edge needed, and the state is IDLE after release.
